regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter AW, default 5, register address width; 2**AW registers (32 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately, independent of clk.
REQ-005 we  input  1  write enable, sampled on rising clk.
REQ-006 waddr  input  AW  write register index.
REQ-007 wdata  input  WIDTH  write data.
REQ-008 raddr_a  input  AW  read port A register index.
REQ-009 raddr_b  input  AW  read port B register index.
REQ-010 rdata_a  output  WIDTH  read port A data.
REQ-011 rdata_b  output  WIDTH  read port B data.
REQ-012 wr_count  output  8  saturating count of committed writes since reset.

Function
REQ-013 Storage SHALL be 2**AW registers of WIDTH bits, each a rising-edge flop with asynchronous active-low clear.
REQ-014 Write SHALL commit wdata to register waddr at rising clk when we=1, waddr!=0 and rst=1; one-cycle write latency.
REQ-015 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-016 Read ports SHALL be combinational: rdata_x = contents of register raddr_x, with zero added cycles of latency.
REQ-017 Bypass: when we=1, waddr!=0 and raddr_x==waddr in the same cycle, rdata_x SHALL equal wdata (write-before-read within the cycle).
REQ-018 Bypass SHALL apply independently to both ports; both ports addressing waddr SHALL both return wdata.
REQ-019 Bypass SHALL NOT apply for index 0; raddr_x=0 returns 0 even when we=1 and waddr=0.
REQ-020 Both read ports reading the same index without a write SHALL return identical data.
REQ-021 wr_count SHALL increment by 1 on each committed write and saturate at 255 (no wrap).
REQ-022 Unknown (X) address values are not defined behaviour; no recovery logic required.
REQ-023 Asynchronous reset de-assertion SHALL take effect at the next rising clk; a write presented in the same cycle as reset de-assertion commits only if rst=1 at that edge.

Reset
REQ-024 While rst=0: all registers = 0, wr_count = 0, rdata_a = rdata_b = 0 regardless of raddr or bypass inputs.
REQ-025 Reset asserted mid-operation (any cycle) SHALL clear all registers without waiting for clk; no pending write survives.
REQ-026 Writes with we=1 while rst=0 SHALL be ignored.

Verification
REQ-027 Reset then read all 32 indices on both ports -> every rdata = 0x00000000, wr_count = 0.
REQ-028 Write 0xDEADBEEF to r5, next cycle raddr_a=5, raddr_b=5 -> both = 0xDEADBEEF, wr_count = 1.
REQ-029 Same-cycle we=1, waddr=7, wdata=0x12345678, raddr_a=7, raddr_b=3 (r3=0xA5A5A5A5) -> rdata_a = 0x12345678 combinationally, rdata_b = 0xA5A5A5A5.
REQ-030 we=1, waddr=0, wdata=0xFFFFFFFF, raddr_a=0 -> rdata_a = 0 in that cycle and after; wr_count unchanged.
REQ-031 Write r1..r31 with index value, then pull rst low between clock edges -> all rdata = 0 before next edge; after release, reads return 0.
REQ-032 300 consecutive writes to r9 -> wr_count saturates at 255; r9 holds last written value.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with a hard-wired zero register,
// same-cycle write-to-read bypass and a saturating committed-write counter.

module regfile_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (wen) data_d = wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_q <= '0;
        else      data_q <= data_d;
    end

    assign q = data_q;
endmodule

module regfile_2r1w #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [7:0]       wr_count
);
    localparam int NREG = 2 ** AW;

    logic [NREG-1:0][WIDTH-1:0] regs;
    logic                       commit;
    logic [7:0]                 cnt_d, cnt_q;

    assign commit  = we && (waddr != '0);
    assign regs[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        regfile_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .wen   (commit && (waddr == AW'(i))),
            .wdata (wdata),
            .q     (regs[i])
        );
    end

    // Reset gates the bypass path too, so nothing leaks out while rst is low.
    function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] r;
        r = regs[ra];
        if (commit && (ra == waddr)) r = wdata;
        if (!rst || (ra == '0))      r = '0;
        return r;
    endfunction

    always_comb begin
        rdata_a = rd_port(raddr_a);
        rdata_b = rd_port(raddr_b);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (commit && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign wr_count = cnt_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed checks for regfile_2r1w: reset, writes, bypass, r0, async reset, saturation.

module tb_regfile_2r1w;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic [7:0]  wr_count;

    int n_cmp = 0;
    int n_err = 0;

    regfile_2r1w #(.WIDTH(32), .AW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

        // Reset held: outputs zero even with a bypass-looking write request
        #12;
        we = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D; raddr_a = 5'd4; raddr_b = 5'd4;
        #1;
        chk("rst_bypass_a", rdata_a, 32'h0);
        chk("rst_bypass_b", rdata_b, 32'h0);
        chk("rst_count", {24'h0, wr_count}, 32'd0);
        @(posedge clk); #1;
        chk("rst_we_ignored_cnt", {24'h0, wr_count}, 32'd0);

        @(negedge clk);
        we = 1'b0; rst = 1'b1;
        #1;
        chk("post_rst_r4", rdata_a, 32'h0);

        // All indices read zero after reset
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            #1;
            chk("init_a", rdata_a, 32'h0);
            chk("init_b", rdata_b, 32'h0);
        end
        chk("init_count", {24'h0, wr_count}, 32'd0);

        // Simple write then read on both ports
        wr(5'd5, 32'hDEADBEEF);
        raddr_a = 5'd5; raddr_b = 5'd5;
        #1;
        chk("r5_a", rdata_a, 32'hDEADBEEF);
        chk("r5_b", rdata_b, 32'hDEADBEEF);
        chk("r5_count", {24'h0, wr_count}, 32'd1);

        // Bypass on port A only, port B reads stored r3
        wr(5'd3, 32'hA5A5A5A5);
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr_a = 5'd7; raddr_b = 5'd3;
        #1;
        chk("byp_a", rdata_a, 32'h12345678);
        chk("byp_b_r3", rdata_b, 32'hA5A5A5A5);
        chk("byp_cnt_before", {24'h0, wr_count}, 32'd2);
        // Both ports bypass
        raddr_b = 5'd7;
        #1;
        chk("byp_both_b", rdata_b, 32'h12345678);
        @(negedge clk);
        we = 1'b0; raddr_a = 5'd3;
        #1;
        chk("r7_stored", rdata_b, 32'h12345678);
        chk("r3_a", rdata_a, 32'hA5A5A5A5);
        chk("cnt_3", {24'h0, wr_count}, 32'd3);

        // Writes to r0 discarded, no bypass for index 0
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr_a = 5'd0; raddr_b = 5'd0;
        #1;
        chk("r0_byp_a", rdata_a, 32'h0);
        chk("r0_byp_b", rdata_b, 32'h0);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("r0_after", rdata_a, 32'h0);
        chk("r0_cnt", {24'h0, wr_count}, 32'd3);

        // Fill r1..r31 with their index
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        raddr_a = 5'd17; raddr_b = 5'd31;
        #1;
        chk("fill_r17", rdata_a, 32'd17);
        chk("fill_r31", rdata_b, 32'd31);
        chk("fill_cnt", {24'h0, wr_count}, 32'd34);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("async_r17", rdata_a, 32'h0);
        chk("async_r31", rdata_b, 32'h0);
        chk("async_cnt", {24'h0, wr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(i);
            #1;
            chk("post_async_a", rdata_a, 32'h0);
            chk("post_async_b", rdata_b, 32'h0);
        end

        // Write presented with reset release in the same cycle commits at that edge
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd6; wdata = 32'h00000066;
        @(negedge clk);
        we = 1'b0; raddr_a = 5'd6;
        #1;
        chk("rel_write_r6", rdata_a, 32'h66);
        chk("rel_write_cnt", {24'h0, wr_count}, 32'd1);

        // Saturation: 300 writes to r9 on top of count 1
        @(negedge clk);
        we = 1'b1; waddr = 5'd9;
        for (int i = 0; i < 300; i++) begin
            wdata = 32'(i);
            @(negedge clk);
            if (i == 253) chk("cnt_255_reach", {24'h0, wr_count}, 32'd255);
        end
        we = 1'b0; raddr_a = 5'd9;
        #1;
        chk("sat_cnt", {24'h0, wr_count}, 32'd255);
        chk("sat_r9", rdata_a, 32'd299);
        @(negedge clk);
        chk("sat_hold", {24'h0, wr_count}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
